// File: rtl/link_test_pkg.sv
// Shared state encoding, widths and default limits for the link test sequencer.
package link_test_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned TIMER_W = 32;
    localparam int unsigned WORD_W  = 32;

    localparam int unsigned DEF_RXVAL_TIMEOUT = 65535;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 65535;
    localparam int unsigned DEF_RUN_WORDS     = 1000000;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 3'd0,
        WAIT_RXVAL = 3'd1,
        WAIT_LOCK  = 3'd2,
        RUN        = 3'd3,
        PASS       = 3'd4,
        FAIL       = 3'd5
    } state_e;

    function automatic logic is_busy(state_e s);
        return (s == WAIT_RXVAL) || (s == WAIT_LOCK) || (s == RUN);
    endfunction

endpackage

// File: rtl/sat_edge_counter.sv
// Rising-edge detector feeding a saturating event counter.
module sat_edge_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr,
    input  logic             arm,
    input  logic             en,
    input  logic             sig,
    output logic             edge_c,
    output logic [CNT_W-1:0] cnt
);

    logic sig_q;

    assign edge_c = en & sig & ~sig_q;

    // Clear beats a same-cycle increment; arm forces the history low so a level already high counts once
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sig_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sig_q <= arm ? 1'b0 : sig;
            if (clr) begin
                cnt <= '0;
            end else if (edge_c && (cnt != '1)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/link_test_sequencer.sv
// Run-control FSM for the Rx count checker: wait for Rx valid and lock, run a
// bounded word count, and latch a PASS/FAIL verdict with cause flags.
module link_test_sequencer
    import link_test_pkg::*;
#(
    parameter int unsigned RXVAL_TIMEOUT = DEF_RXVAL_TIMEOUT,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned RUN_WORDS     = DEF_RUN_WORDS,
    parameter int unsigned CNT_W         = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               cmd_start_i,
    input  logic               cmd_stop_i,
    input  logic               cmd_clear_i,
    input  logic               rx_val_i,
    input  logic               usr_data_valid_i,
    input  logic               lock_i,
    input  logic               error_i,
    input  logic               crc_error_i,
    output logic               start_o,
    output logic               clear_o,
    output logic               busy_o,
    output logic               pass_o,
    output logic               fail_o,
    output logic               timeout_o,
    output logic               link_down_o,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   err_cnt_o,
    output logic [CNT_W-1:0]   crc_cnt_o,
    output logic [WORD_W-1:0]  word_cnt_o
);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
    logic                 start_go, cnt_clr, arm, run_en;
    logic                 err_edge, crc_edge, clean;
    logic                 word_inc, word_last;
    logic                 set_timeout, set_link_down;

    assign run_en  = (state_q == RUN);
    assign state_o = state_q;

    sat_edge_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr     (cnt_clr),
        .arm     (arm),
        .en      (run_en),
        .sig     (error_i),
        .edge_c  (err_edge),
        .cnt     (err_cnt_o)
    );

    sat_edge_counter #(.CNT_W(CNT_W)) u_crc_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr     (cnt_clr),
        .arm     (arm),
        .en      (run_en),
        .sig     (crc_error_i),
        .edge_c  (crc_edge),
        .cnt     (crc_cnt_o)
    );

    // Next state; stop suppresses a same-cycle start everywhere
    always_comb begin
        state_d       = state_q;
        start_go      = 1'b0;
        set_timeout   = 1'b0;
        set_link_down = 1'b0;
        timer_inc     = timer_q + TIMER_W'(1);
        word_inc      = run_en && usr_data_valid_i && (word_cnt_o < WORD_W'(RUN_WORDS));
        word_last     = word_inc && ((word_cnt_o + WORD_W'(1)) == WORD_W'(RUN_WORDS));
        clean         = (err_cnt_o == '0) && !err_edge && (crc_cnt_o == '0) && !crc_edge;

        case (state_q)
            IDLE, PASS, FAIL: begin
                if (cmd_start_i && !cmd_stop_i) begin
                    start_go = 1'b1;
                    state_d  = WAIT_RXVAL;
                end
            end
            WAIT_RXVAL: begin
                if (cmd_stop_i) begin
                    state_d = IDLE;
                end else if (rx_val_i) begin
                    state_d = WAIT_LOCK;
                end else if (timer_inc >= TIMER_W'(RXVAL_TIMEOUT)) begin
                    state_d     = FAIL;
                    set_timeout = 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (cmd_stop_i) begin
                    state_d = IDLE;
                end else if (!rx_val_i) begin
                    state_d = WAIT_RXVAL;
                end else if (lock_i && !error_i) begin
                    state_d = RUN;
                end else if (timer_inc >= TIMER_W'(LOCK_TIMEOUT)) begin
                    state_d     = FAIL;
                    set_timeout = 1'b1;
                end
            end
            RUN: begin
                if (!rx_val_i) begin
                    state_d       = FAIL;
                    set_link_down = 1'b1;
                end else if (cmd_stop_i || word_last) begin
                    state_d = clean ? PASS : FAIL;
                end
            end
            default: state_d = IDLE;
        endcase

        arm     = (state_d == RUN) && (state_q != RUN);
        cnt_clr = cmd_clear_i || start_go;
        timer_d = ((state_d == state_q) && ((state_q == WAIT_RXVAL) || (state_q == WAIT_LOCK)))
                  ? timer_inc : '0;
    end

    // State, timer and registered outputs, all updated on the same edge
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            start_o     <= 1'b0;
            clear_o     <= 1'b0;
            busy_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            timeout_o   <= 1'b0;
            link_down_o <= 1'b0;
            word_cnt_o  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            start_o <= (state_d == WAIT_LOCK) || (state_d == RUN);
            clear_o <= cmd_clear_i || ((state_d == WAIT_LOCK) && (state_q != WAIT_LOCK));
            busy_o  <= is_busy(state_d);
            pass_o  <= (state_d == PASS);
            fail_o  <= (state_d == FAIL);

            if (cnt_clr) begin
                timeout_o   <= 1'b0;
                link_down_o <= 1'b0;
            end
            if (set_timeout) begin
                timeout_o <= 1'b1;
            end
            if (set_link_down) begin
                link_down_o <= 1'b1;
            end

            if (cnt_clr) begin
                word_cnt_o <= '0;
            end else if (word_inc) begin
                word_cnt_o <= word_cnt_o + WORD_W'(1);
            end
        end
    end

endmodule

// File: doc/link_test_sequencer.md
Name: link_test_sequencer

Overview:
- Run-control FSM for the Rx count checker.
- Turns UART_IF commands (start/stop/clear) into the checker's start and clear strobes.
- Waits for transceiver Rx valid, then for checker lock, then runs a bounded test of RUN_WORDS user words.
- Counts error and CRC events, and reports a latched PASS/FAIL verdict with cause flags back to UART_IF.

Parameters:
RXVAL_TIMEOUT, 65535, max cycles in WAIT_RXVAL before timeout (>=1)
LOCK_TIMEOUT, 65535, max cycles in WAIT_LOCK before timeout (>=1)
RUN_WORDS, 32'd1000000, user-valid words counted in RUN before verdict (>=1)
CNT_W, 16, width of error/CRC event counters (saturating)

Ports:
clk_i  in  1  transceiver Rx clock; all inputs synchronous to it
reset_i  in  1  asynchronous, active-high reset
cmd_start_i  in  1  one-cycle start command from UART_IF
cmd_stop_i  in  1  one-cycle stop command from UART_IF
cmd_clear_i  in  1  one-cycle clear command from UART_IF
rx_val_i  in  1  transceiver Rx valid
usr_data_valid_i  in  1  user data valid from LiteFast Rx
lock_i  in  1  checker lock
error_i  in  1  checker data-mismatch error
crc_error_i  in  1  checker CRC error
start_o  out  1  checker start enable
clear_o  out  1  checker clear strobe (one cycle)
busy_o  out  1  high in WAIT_RXVAL, WAIT_LOCK, RUN
pass_o  out  1  high in PASS
fail_o  out  1  high in FAIL
timeout_o  out  1  sticky: FAIL was caused by a timeout
link_down_o  out  1  sticky: FAIL was caused by rx_val_i dropping during RUN
state_o  out  3  current state encoding
err_cnt_o  out  CNT_W  error_i rising edges seen in RUN
crc_cnt_o  out  CNT_W  crc_error_i rising edges seen in RUN
word_cnt_o  out  32  usr_data_valid_i words counted in RUN

Behaviour:
- Reset:
  - state = IDLE (3'd0).
  - All outputs 0; all counters 0; edge-detect registers 0.
- State encoding: IDLE=0, WAIT_RXVAL=1, WAIT_LOCK=2, RUN=3, PASS=4, FAIL=5. Codes 6 and 7 recover to IDLE on the next cycle.
- All outputs are registered and change in the same cycle as the state register.
- Transitions:
  - IDLE: cmd_start_i -> WAIT_RXVAL. On that transition, clear err/crc/word counters, timeout_o and link_down_o.
  - WAIT_RXVAL:
    - rx_val_i=1 -> WAIT_LOCK.
    - Timer reaches RXVAL_TIMEOUT -> FAIL with timeout_o=1.
    - The timer restarts at 0 on entry to each wait state.
  - WAIT_LOCK:
    - start_o=1.
    - clear_o pulses in the first cycle of this state to flush stale checker error.
    - lock_i=1 and error_i=0 -> RUN.
    - Timer reaches LOCK_TIMEOUT -> FAIL with timeout_o=1.
    - rx_val_i=0 -> back to WAIT_RXVAL.
  - RUN:
    - start_o=1.
    - word_cnt increments on each usr_data_valid_i.
    - Edge-detect registers are loaded with 0 on entry.
    - A rising edge of error_i increments err_cnt; a rising edge of crc_error_i increments crc_cnt.
    - rx_val_i=0 -> FAIL with link_down_o=1.
    - When word_cnt reaches RUN_WORDS (the cycle the RUN_WORDS-th word is counted), evaluate the verdict: err_cnt==0 and crc_cnt==0, including any edge in that same cycle -> PASS, else -> FAIL.
  - PASS/FAIL:
    - Hold the verdict; start_o=0; counters frozen.
    - cmd_start_i restarts exactly as from IDLE.
- cmd_stop_i:
  - In WAIT_RXVAL or WAIT_LOCK -> IDLE, no verdict.
  - In RUN -> immediate verdict evaluation, as at RUN_WORDS.
  - In IDLE, PASS or FAIL: ignored.
- Simultaneous commands:
  - cmd_stop_i and cmd_start_i together: stop wins.
  - cmd_clear_i with any other command: clear is applied and the other command is also honoured.
- cmd_clear_i, in any state:
  - Zeroes err_cnt, crc_cnt and word_cnt.
  - Clears timeout_o and link_down_o.
  - Pulses clear_o for one cycle; does not change state.
  - Clear beats a same-cycle count increment (counter reads 0).
- Counters:
  - err_cnt and crc_cnt saturate at all-ones.
  - word_cnt never exceeds RUN_WORDS.
  - Timers are 32 bits; compare is >= against the parameter.
- start_o drops in the first cycle after leaving RUN or WAIT_LOCK.
- A reset asserted mid-operation returns to IDLE immediately, asynchronously.

Decomposition:
- Shared package link_test_pkg holds:
  - the state localparams (IDLE..FAIL),
  - STATE_W=3,
  - default timeout constants.
- One sub-module, sat_edge_counter:
  - Parameter CNT_W; inputs clk_i, reset_i, clr, arm, en, sig.
  - Rising-edge detector plus saturating counter.
  - Instantiated twice, for error_i and crc_error_i.

Test Plan (bench params RXVAL_TIMEOUT=16, LOCK_TIMEOUT=16, RUN_WORDS=8, CNT_W=4):
- Clean run: cmd_start, rx_val=1, lock=1 after 5 cycles, 8 valid words, no errors -> start_o high from first WAIT_LOCK cycle, PASS, word_cnt=8, err_cnt=0, pass_o=1.
- Error events: in RUN, pulse error_i high at words 2 and 5 and crc_error_i once -> FAIL, err_cnt=2, crc_cnt=1, timeout_o=0.
- Lock timeout: rx_val=1, lock held 0 -> FAIL 16 cycles after entering WAIT_LOCK, timeout_o=1, start_o=0.
- Link drop: rx_val falls after word 3 in RUN -> FAIL, link_down_o=1, word_cnt=3.
- Saturation and clear: 20 error_i edges in RUN -> err_cnt=15. cmd_clear in the same cycle as an edge -> err_cnt=0 and a one-cycle clear_o.
- Command races: cmd_start and cmd_stop together in WAIT_LOCK -> IDLE. reset_i pulsed mid-RUN -> IDLE, all outputs 0 without waiting for a clock edge.
